// File: rtl/uart_frame_parser.sv
// Frame parser behind a UART byte receiver: hunts SYNC/LEN/payload/CHK frames, verifies the
// additive checksum and streams good payloads out over valid/ready.
module uart_frame_parser #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned MAX_LEN   = 64,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_ok,
  output logic       crc_err,
  output logic       len_err,
  output logic       timeout_err,
  output logic       overrun_err,
  output logic       busy
);

  localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT);
  localparam logic [7:0] MaxLen8 = 8'(MAX_LEN);
  // Expiry fires on the idle cycle whose increment would reach TIMEOUT-1.
  localparam logic [TmoW-1:0] TmoLimit = TmoW'(TIMEOUT - 2);

  typedef enum logic [2:0] {StHunt, StLen, StPayload, StCheck, StDrain} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [7:0]      len_q, len_d, sum_q, sum_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            frame_ok_d, crc_err_d, len_err_d, timeout_err_d, overrun_err_d;
  logic            mem_we, in_frame, tmo_expire, last_beat;
  logic [7:0]      chk_sum;
  logic [7:0]      mem_q [MAX_LEN];

  assign in_frame   = state_q inside {StLen, StPayload, StCheck};
  assign tmo_expire = in_frame && !rx_valid && (tmo_q == TmoLimit);
  assign last_beat  = 8'(rd_idx_q) == len_q - 8'd1;
  assign chk_sum    = sum_q + rx_data;

  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    len_d         = len_q;
    sum_d         = sum_q;
    tmo_d         = '0;
    mem_we        = 1'b0;
    frame_ok_d    = 1'b0;
    crc_err_d     = 1'b0;
    len_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    overrun_err_d = 1'b0;

    if (in_frame && !rx_valid) begin
      tmo_d = tmo_q + 1'b1;
    end

    unique case (state_q)
      StHunt: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = StLen;
        end
      end
      StLen: begin
        if (rx_valid) begin
          if (rx_data == 8'd0 || rx_data > MaxLen8) begin
            len_err_d = 1'b1;
            state_d   = StHunt;
          end else begin
            len_d    = rx_data;
            sum_d    = rx_data;
            wr_idx_d = '0;
            state_d  = StPayload;
          end
        end
      end
      StPayload: begin
        if (rx_valid) begin
          mem_we   = 1'b1;
          sum_d    = sum_q + rx_data;
          wr_idx_d = wr_idx_q + 1'b1;
          if (8'(wr_idx_q) == len_q - 8'd1) begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (rx_valid) begin
          if (chk_sum == 8'd0) begin
            frame_ok_d = 1'b1;
            rd_idx_d   = '0;
            state_d    = StDrain;
          end else begin
            crc_err_d = 1'b1;
            state_d   = StHunt;
          end
        end
      end
      StDrain: begin
        // The receiver cannot be stalled, so anything arriving now is lost.
        overrun_err_d = rx_valid;
        if (out_ready) begin
          rd_idx_d = rd_idx_q + 1'b1;
          if (last_beat) begin
            state_d = StHunt;
          end
        end
      end
      default: state_d = StHunt;
    endcase

    if (tmo_expire) begin
      timeout_err_d = 1'b1;
      state_d       = StHunt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHunt;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      len_q       <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
      frame_ok    <= 1'b0;
      crc_err     <= 1'b0;
      len_err     <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
      frame_ok    <= frame_ok_d;
      crc_err     <= crc_err_d;
      len_err     <= len_err_d;
      timeout_err <= timeout_err_d;
      overrun_err <= overrun_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_idx_q] <= rx_data;
    end
  end

  assign out_valid = state_q == StDrain;
  assign out_data  = out_valid ? mem_q[rd_idx_q] : 8'd0;
  assign out_last  = out_valid && last_beat;
  assign busy      = state_q != StHunt;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: directed frame table, hand-written corner sequences and random
// byte streams checked cycle by cycle against a byte-queue reference model.
module tb_uart_frame_parser;

  localparam logic [7:0] Sync = 8'hA5;
  localparam int MaxLen = 64;
  localparam int Tmo = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, out_last, frame_ok, crc_err, len_err, timeout_err, overrun_err, busy;

  uart_frame_parser #(
    .SYNC_BYTE(Sync),
    .MAX_LEN  (MaxLen),
    .TIMEOUT  (Tmo)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .frame_ok   (frame_ok),
    .crc_err    (crc_err),
    .len_err    (len_err),
    .timeout_err(timeout_err),
    .overrun_err(overrun_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Expected pulse vector {ok, crc, len, tmo, ovr} keyed by cycle; absent means all low.
  logic [4:0] sched [int];
  logic [8:0] exp_q [$];   // {last, data} in delivery order
  logic [7:0] got_q [$];
  int n_ok = 0, n_crc = 0, n_len = 0, n_tmo = 0, n_ovr = 0;
  int tmo_cyc = 0, last_tx = 0;
  bit prev_stall = 1'b0;
  logic [9:0] prev_word = '0;
  int ready_mode = 0;      // 0: always ready, 1: random, 2: from rdy_seq
  bit rdy_seq [$];

  // Reference model state: bytes seen since SYNC, cycle of last accepted byte, drain backlog.
  bit m_in_frame = 1'b0;
  logic [7:0] m_fq [$];
  int m_last = 0, m_drain = 0, m_ok_cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic model(input int c, input bit v, input logic [7:0] b, input bit rdy);
    int s;
    int len;
    if (v) begin
      if (m_drain > 0) begin
        sched[c + 1] = 5'b00001;
      end else if (!m_in_frame) begin
        if (b == Sync) begin
          m_in_frame = 1'b1;
          m_fq.delete();
          m_last = c;
        end
      end else begin
        m_fq.push_back(b);
        m_last = c;
        len = int'(m_fq[0]);
        if (m_fq.size() == 1) begin
          if (len == 0 || len > MaxLen) begin
            sched[c + 1] = 5'b00100;
            m_in_frame = 1'b0;
          end
        end else if (m_fq.size() == len + 2) begin
          s = 0;
          foreach (m_fq[i]) s += int'(m_fq[i]);
          if (s % 256 == 0) begin
            sched[c + 1] = 5'b10000;
            for (int i = 1; i <= len; i++) exp_q.push_back({(i == len), m_fq[i]});
            m_drain = len;
            m_ok_cyc = c;
          end else begin
            sched[c + 1] = 5'b01000;
          end
          m_in_frame = 1'b0;
        end
      end
    end else if (m_in_frame && c - m_last == Tmo - 1) begin
      sched[c + 1] = 5'b00010;
      m_in_frame = 1'b0;
    end
    if (m_drain > 0 && c > m_ok_cyc && rdy) m_drain--;
  endtask

  task automatic sample();
    logic [4:0] e;
    logic [8:0] ew;
    e = sched.exists(cyc) ? sched[cyc] : 5'b0;
    check("pulses", 32'({frame_ok, crc_err, len_err, timeout_err, overrun_err}), 32'(e));
    n_ok += int'(frame_ok);
    n_crc += int'(crc_err);
    n_len += int'(len_err);
    n_ovr += int'(overrun_err);
    if (timeout_err) begin
      n_tmo++;
      tmo_cyc = cyc;
    end
    if (prev_stall) check("out_hold", 32'({out_valid, out_last, out_data}), 32'(prev_word));
    prev_stall = out_valid && !out_ready;
    prev_word = {out_valid, out_last, out_data};
    if (out_valid && exp_q.size() == 0) check("out_unexpected", 32'(out_valid), 32'd0);
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      if (exp_q.size() > 0) begin
        ew = exp_q.pop_front();
        check("out_byte", 32'({out_last, out_data}), 32'(ew));
      end
    end
  endtask

  task automatic step(input bit v, input logic [7:0] b);
    bit rdy;
    case (ready_mode)
      0: rdy = 1'b1;
      1: rdy = ($urandom_range(0, 3) != 0);
      default: rdy = (rdy_seq.size() > 0) ? rdy_seq.pop_front() : 1'b1;
    endcase
    rx_valid = v;
    rx_data = v ? b : 8'h00;
    out_ready = rdy;
    if (v) last_tx = cyc;
    model(cyc, v, b, rdy);
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap - 1) step(1'b0, 8'h00);
    step(1'b1, b);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_valid = 1'b0;
    out_ready = 1'b0;
    sched.delete();
    exp_q.delete();
    m_in_frame = 1'b0;
    m_drain = 0;
    prev_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic int rgap();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(Tmo - 2, Tmo + 1))
                                       : int'($urandom_range(2, 5));
  endfunction

  typedef struct packed {
    int unsigned n;
    logic [63:0] b;      // bytes sent MSB first
    int unsigned ok;
    int unsigned crc;
    int unsigned len;
    int unsigned nout;
    logic [23:0] o;      // expected payload MSB first
  } vec_t;

  vec_t tbl [8];

  initial begin
    int b_ok, b_crc, b_len, b_tmo, b_ovr, g0, t0;
    logic [7:0] sum, pb;
    logic [7:0] pat [$];

    tbl[0] = '{6, 64'hA503_1122_3397_0000, 1, 0, 0, 3, 24'h112233};
    tbl[1] = '{6, 64'hA503_1122_3398_0000, 0, 1, 0, 0, 24'h000000};
    tbl[2] = '{2, 64'hA500_0000_0000_0000, 0, 0, 1, 0, 24'h000000};
    tbl[3] = '{2, 64'hA541_0000_0000_0000, 0, 0, 1, 0, 24'h000000};
    tbl[4] = '{4, 64'hA501_7F80_0000_0000, 1, 0, 0, 1, 24'h7F0000};
    tbl[5] = '{8, 64'h00FF_5AA5_0201_02FB, 1, 0, 0, 2, 24'h010200};
    tbl[6] = '{4, 64'hA501_A55A_0000_0000, 1, 0, 0, 1, 24'hA50000};
    tbl[7] = '{2, 64'hA5A5_0000_0000_0000, 0, 0, 1, 0, 24'h000000};

    #2;
    check("reset_outputs", 32'({out_data, out_valid, out_last, frame_ok, crc_err, len_err,
                                timeout_err, overrun_err, busy}), 32'd0);
    do_reset();

    // Directed frame table, strobes 10 cycles apart, sink always ready.
    for (int v = 0; v < 8; v++) begin
      b_ok = n_ok; b_crc = n_crc; b_len = n_len; g0 = got_q.size();
      for (int i = 0; i < int'(tbl[v].n); i++) send(tbl[v].b[63 - 8*i -: 8], 10);
      idle(12);
      check($sformatf("tbl%0d_ok", v), 32'(n_ok - b_ok), tbl[v].ok);
      check($sformatf("tbl%0d_crc", v), 32'(n_crc - b_crc), tbl[v].crc);
      check($sformatf("tbl%0d_len", v), 32'(n_len - b_len), tbl[v].len);
      check($sformatf("tbl%0d_nout", v), 32'(got_q.size() - g0), tbl[v].nout);
      for (int i = 0; i < int'(tbl[v].nout) && g0 + i < got_q.size(); i++)
        check($sformatf("tbl%0d_out%0d", v, i), 32'(got_q[g0 + i]), 32'(tbl[v].o[23 - 8*i -: 8]));
      check($sformatf("tbl%0d_busy", v), 32'(busy), 32'd0);
    end

    // Inter-byte timeout, then a byte landing exactly on the expiry cycle.
    b_tmo = n_tmo;
    send(Sync, 10); send(8'h03, 10); send(8'h11, 10);
    t0 = last_tx;
    idle(Tmo + 5);
    check("tmo_count", 32'(n_tmo - b_tmo), 32'd1);
    check("tmo_delay", 32'(tmo_cyc - t0), 32'(Tmo));
    check("tmo_busy", 32'(busy), 32'd0);
    b_ok = n_ok;
    send(Sync, 10); send(8'h03, 10); send(8'h11, 10);
    send(8'h22, Tmo - 1); send(8'h33, Tmo - 1); send(8'h97, Tmo - 1);
    idle(8);
    check("tmo_edge_none", 32'(n_tmo - b_tmo), 32'd1);
    check("tmo_edge_ok", 32'(n_ok - b_ok), 32'd1);

    // Stalled drain with an overrun byte in the middle.
    b_ok = n_ok; b_ovr = n_ovr; g0 = got_q.size();
    send(Sync, 10); send(8'h02, 10); send(8'hAA, 10); send(8'hBB, 10); send(8'h99, 10);
    ready_mode = 2;
    rdy_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
    step(1'b0, 8'h00); step(1'b1, 8'h55); step(1'b0, 8'h00); step(1'b0, 8'h00);
    ready_mode = 0;
    idle(5);
    check("drain_ok", 32'(n_ok - b_ok), 32'd1);
    check("drain_ovr", 32'(n_ovr - b_ovr), 32'd1);
    check("drain_nout", 32'(got_q.size() - g0), 32'd2);
    if (got_q.size() >= g0 + 2) check("drain_bytes", 32'({got_q[g0], got_q[g0 + 1]}), 32'hAABB);

    // Reset in the middle of a payload aborts silently; the next frame parses normally.
    send(Sync, 3); send(8'h04, 3); send(8'h01, 3); send(8'h02, 3);
    check("busy_mid_frame", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_abort", 32'({out_data, out_valid, out_last, frame_ok, crc_err, len_err,
                              timeout_err, overrun_err, busy}), 32'd0);
    do_reset();
    b_ok = n_ok;
    send(Sync, 4); send(8'h01, 4); send(8'h7F, 4); send(8'h80, 4);
    idle(4);
    check("post_reset_ok", 32'(n_ok - b_ok), 32'd1);

    // Maximum length, strobes every other cycle.
    b_ok = n_ok; g0 = got_q.size();
    pat.delete();
    sum = 8'(MaxLen);
    send(Sync, 2); send(8'(MaxLen), 2);
    for (int i = 0; i < MaxLen; i++) begin
      pb = 8'(i * 7 + 3);
      pat.push_back(pb);
      sum = sum + pb;
      send(pb, 2);
    end
    send(8'd0 - sum, 2);
    idle(MaxLen + 4);
    check("maxlen_ok", 32'(n_ok - b_ok), 32'd1);
    check("maxlen_nout", 32'(got_q.size() - g0), 32'(MaxLen));
    for (int i = 0; i < MaxLen && g0 + i < got_q.size(); i += 9)
      check($sformatf("maxlen_out%0d", i), 32'(got_q[g0 + i]), 32'(pat[i]));

    // Random frames, errors and noise with a randomly stalling sink.
    ready_mode = 1;
    for (int u = 0; u < 60; u++) begin
      int kind, len;
      kind = $urandom_range(0, 4);
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MaxLen))
                                        : int'($urandom_range(1, 6));
      case (kind)
        3: begin
          send(Sync, rgap());
          send(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MaxLen + 1, 255)), rgap());
        end
        4: repeat ($urandom_range(1, 3)) send(8'($urandom_range(0, 255)), rgap());
        default: begin
          send(Sync, rgap());
          send(8'(len), rgap());
          sum = 8'(len);
          for (int i = 0; i < len; i++) begin
            pb = 8'($urandom_range(0, 255));
            sum = sum + pb;
            send(pb, rgap());
          end
          pb = 8'd0 - sum;
          if (kind == 2) pb = pb + 8'd1;
          send(pb, rgap());
        end
      endcase
      idle($urandom_range(0, 6));
    end
    ready_mode = 0;
    idle(3 * MaxLen);
    check("drain_complete", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
